cpu_status_writer: RTL and testbench

Drives the write side of the CPU status-register interface. It samples the execute-stage ALU outputs once per instruction cycle, derives the C, DC and Z flags, and detects direct file writes to STATUS. It then issues one-clock load strobes with the matching data on the status-register input lanes. It sits between the ALU/execute control and the status register, and owns the four-phase (Q0–Q3) instruction timing used for the flag update.

---
 rtl/cpu_status_writer_pkg.sv | 46 ++++
 rtl/cpu_qphase_counter.sv | 39 +++
 rtl/cpu_status_writer.sv | 113 +++++++++++
 tb/tb_cpu_status_writer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_status_writer_pkg.sv
// Purpose : shared STATUS-interface definitions (flag bit positions, file address, Q-phase encodings).
// Latency : n/a (definitions only).
// Backpr. : n/a (definitions only).
package cpu_status_writer_pkg;

    // Bit positions of the flags inside STATUS and inside the 3-bit flag lanes
    localparam int STATUS_C  = 0;
    localparam int STATUS_DC = 1;
    localparam int STATUS_Z  = 2;

    // File-register address of STATUS
    localparam logic [4:0] DEF_STATUS_ADDR = 5'h03;

    // Four-phase instruction timing
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } q_phase_e;

    // Flag lane layout {Z,DC,C}
    typedef struct packed {
        logic z;
        logic dc;
        logic c;
    } flags_t;

    // Execute-stage state sampled once per instruction
    typedef struct packed {
        logic       valid;
        logic       hit;
        logic [2:0] mask;
        flags_t     flags;
        logic [7:0] result;
    } capture_t;

    // One-clock load strobes towards the status register
    typedef struct packed {
        logic ld;
        logic z;
        logic dc;
        logic c;
    } strobe_t;

endpackage

// File: rtl/cpu_qphase_counter.sv
// Purpose : 2-bit Q0..Q3 instruction phase counter, reusable by fetch/decode.
// Latency : advances one phase per clk edge; q_phase is the registered state.
// Backpr. : stall=1 holds the current phase.
// Ports   : clk, rst (async active-low), stall -> q_phase[1:0]
module cpu_qphase_counter
    import cpu_status_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    output logic [1:0] q_phase
);

    q_phase_e phase_q;
    q_phase_e phase_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= Q0;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (!stall) begin
            case (phase_q)
                Q0:      phase_d = Q1;
                Q1:      phase_d = Q2;
                Q2:      phase_d = Q3;
                default: phase_d = Q0;
            endcase
        end
    end

    assign q_phase = phase_q;

endmodule

// File: rtl/cpu_status_writer.sv
// Purpose : samples execute-stage ALU outputs, derives C/DC/Z, detects STATUS file writes, drives status load strobes.
// Latency : inputs sampled on the edge ending Q_CAPTURE; strobes high for the first clk of Q_WRITE.
// Backpr. : stall freezes phase and captured state; a stalled Q_WRITE keeps strobes for one clk only.
// Ports   : clk, rst (async active-low), stall, ex_valid, ex_squash, ex_flag_mask[2:0] {Z,DC,C},
//           alu_result[7:0], alu_c, alu_dc, ex_dest_file, ex_file_addr[4:0]
//           -> q_phase[1:0], alu_to_status[7:0], status_bus[2:0], load_status_reg,
//              status_c_load, status_dc_load, status_z_load
module cpu_status_writer
    import cpu_status_writer_pkg::*;
#(
    parameter logic [4:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter logic [1:0] Q_CAPTURE   = 2'd2,
    parameter logic [1:0] Q_WRITE     = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       ex_valid,
    input  logic       ex_squash,
    input  logic [2:0] ex_flag_mask,
    input  logic [7:0] alu_result,
    input  logic       alu_c,
    input  logic       alu_dc,
    input  logic       ex_dest_file,
    input  logic [4:0] ex_file_addr,
    output logic [1:0] q_phase,
    output logic [7:0] alu_to_status,
    output logic [2:0] status_bus,
    output logic       load_status_reg,
    output logic       status_c_load,
    output logic       status_dc_load,
    output logic       status_z_load
);

    // Strobes are loaded on the edge that enters Q_WRITE
    localparam logic [1:0] PRE_WRITE = Q_WRITE - 2'd1;

    logic [1:0] q_phase_w;
    logic       capture_en;
    logic       write_en;

    capture_t   cap_q;
    capture_t   cap_d;
    strobe_t    strb_q;
    strobe_t    strb_d;
    flags_t     bus_q;
    flags_t     bus_d;
    logic [7:0] data_q;
    logic [7:0] data_d;

    cpu_qphase_counter u_qphase (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .q_phase (q_phase_w)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_q  <= '0;
            strb_q <= '0;
            bus_q  <= '0;
            data_q <= '0;
        end else begin
            cap_q  <= cap_d;
            strb_q <= strb_d;
            bus_q  <= bus_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        capture_en = !stall && (q_phase_w == Q_CAPTURE);
        write_en   = !stall && (q_phase_w == PRE_WRITE);

        cap_d  = cap_q;
        strb_d = '0;
        bus_d  = bus_q;
        data_d = data_q;

        if (capture_en) begin
            cap_d.valid    = ex_valid & ~ex_squash;
            cap_d.hit      = ex_dest_file & (ex_file_addr == STATUS_ADDR);
            cap_d.mask     = ex_flag_mask;
            cap_d.flags.z  = (alu_result == 8'h00);
            cap_d.flags.dc = alu_dc;
            cap_d.flags.c  = alu_c;
            cap_d.result   = alu_result;
        end

        // Uses cap_d so capture and strobe load may share one edge (default Q2 -> Q3)
        if (write_en) begin
            strb_d.c  = cap_d.valid & cap_d.mask[STATUS_C];
            strb_d.dc = cap_d.valid & cap_d.mask[STATUS_DC];
            strb_d.z  = cap_d.valid & cap_d.mask[STATUS_Z];
            strb_d.ld = cap_d.valid & cap_d.hit;
            // Data lanes only move together with a strobe; otherwise they hold
            if (strb_d != '0) begin
                bus_d  = cap_d.flags;
                data_d = cap_d.result;
            end
        end
    end

    assign q_phase         = q_phase_w;
    assign alu_to_status   = data_q;
    assign status_bus      = bus_q;
    assign load_status_reg = strb_q.ld;
    assign status_c_load   = strb_q.c;
    assign status_dc_load  = strb_q.dc;
    assign status_z_load   = strb_q.z;

endmodule

// File: tb/tb_cpu_status_writer.sv
module tb_cpu_status_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       ex_valid = 1'b0;
    logic       ex_squash = 1'b0;
    logic [2:0] ex_flag_mask = 3'b000;
    logic [7:0] alu_result = 8'h00;
    logic       alu_c = 1'b0;
    logic       alu_dc = 1'b0;
    logic       ex_dest_file = 1'b0;
    logic [4:0] ex_file_addr = 5'h00;
    logic [1:0] q_phase;
    logic [7:0] alu_to_status;
    logic [2:0] status_bus;
    logic       load_status_reg;
    logic       status_c_load;
    logic       status_dc_load;
    logic       status_z_load;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    cpu_status_writer dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_valid        (ex_valid),
        .ex_squash       (ex_squash),
        .ex_flag_mask    (ex_flag_mask),
        .alu_result      (alu_result),
        .alu_c           (alu_c),
        .alu_dc          (alu_dc),
        .ex_dest_file    (ex_dest_file),
        .ex_file_addr    (ex_file_addr),
        .q_phase         (q_phase),
        .alu_to_status   (alu_to_status),
        .status_bus      (status_bus),
        .load_status_reg (load_status_reg),
        .status_c_load   (status_c_load),
        .status_dc_load  (status_dc_load),
        .status_z_load   (status_z_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An instruction cycle is four un-stalled clocks; the instruction that is
    // presented when a Q2 finishes decides the strobes of the following clock.
    int         m_phase = 0;
    logic [3:0] m_strb  = 4'd0;   // {load_status_reg, z, dc, c}
    logic [2:0] m_bus   = 3'd0;
    logic [7:0] m_data  = 8'd0;

    function automatic logic [3:0] instr_strobes();
        if (!ex_valid || ex_squash) return 4'd0;
        return {(ex_dest_file && ex_file_addr == 5'h03), ex_flag_mask};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_strb  <= 4'd0;
            m_bus   <= 3'd0;
            m_data  <= 8'd0;
        end else begin
            m_strb <= 4'd0;
            if (!stall) begin
                m_phase <= (m_phase + 1) % 4;
                if (m_phase == 2 && instr_strobes() != 4'd0) begin
                    m_strb <= instr_strobes();
                    m_bus  <= {(alu_result == 8'h00), alu_dc, alu_c};
                    m_data <= alu_result;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model q_phase", 32'(q_phase), 32'(m_phase));
            chk("model strobes", 32'({load_status_reg, status_z_load, status_dc_load, status_c_load}), 32'(m_strb));
            chk("model status_bus", 32'(status_bus), 32'(m_bus));
            chk("model alu_to_status", 32'(alu_to_status), 32'(m_data));
        end
    end

    // ---------------- directed stimulus ----------------
    // Runs one instruction cycle from Q0; checks the first Q3 clock against
    // hand-computed values. Optional stalls in Q2 / Q3 and reset in Q3.
    task automatic do_instr(input string name,
                            input logic v, input logic sq, input logic [2:0] mask,
                            input logic [7:0] res, input logic c, input logic dc,
                            input logic dest, input logic [4:0] addr,
                            input int stall_q2, input int stall_q3, input bit rst_q3,
                            input logic [3:0] exp_strb, input logic [2:0] exp_bus,
                            input logic [7:0] exp_data);
        int guard = 0;
        int high_cnt = 0;
        while (q_phase != 2'd0 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        chk({name, " align Q0"}, 32'(q_phase), 32'd0);
        ex_valid = v; ex_squash = sq; ex_flag_mask = mask; alu_result = res;
        alu_c = c; alu_dc = dc; ex_dest_file = dest; ex_file_addr = addr;
        @(negedge clk);
        @(negedge clk);
        if (stall_q2 > 0) begin
            stall = 1'b1;
            repeat (stall_q2) @(negedge clk);
            stall = 1'b0;
        end
        @(negedge clk);
        chk({name, " q_phase"}, 32'(q_phase), 32'd3);
        chk({name, " strobes"}, 32'({load_status_reg, status_z_load, status_dc_load, status_c_load}), 32'(exp_strb));
        chk({name, " status_bus"}, 32'(status_bus), 32'(exp_bus));
        chk({name, " alu_to_status"}, 32'(alu_to_status), 32'(exp_data));
        if (rst_q3) begin
            #2 rst = 1'b0;
            #1;
            chk({name, " async reset outputs"},
                32'({q_phase, load_status_reg, status_z_load, status_dc_load, status_c_load, status_bus, alu_to_status}),
                32'd0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            #1 chk({name, " q_phase after release"}, 32'(q_phase), 32'd0);
        end else begin
            if (exp_strb != 4'd0) high_cnt = 1;
            if (stall_q3 > 0) begin
                stall = 1'b1;
                for (int i = 0; i < stall_q3; i++) begin
                    @(negedge clk);
                    chk({name, " stalled Q3 phase"}, 32'(q_phase), 32'd3);
                    if ({load_status_reg, status_z_load, status_dc_load, status_c_load} != 4'd0) high_cnt++;
                end
                stall = 1'b0;
                chk({name, " strobe clocks"}, 32'(high_cnt), (exp_strb != 4'd0) ? 32'd1 : 32'd0);
            end
            @(negedge clk);
            chk({name, " next q_phase"}, 32'(q_phase), 32'd0);
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        #3;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset state", 32'({q_phase, load_status_reg, status_z_load, status_dc_load, status_c_load, status_bus, alu_to_status}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        //        name            v  sq  mask    res    c  dc dest addr  sQ2 sQ3 rst  strb     bus     data
        do_instr("addwf",         1, 0, 3'b111, 8'h00, 1, 1, 0, 5'h03, 0, 0, 0, 4'b0111, 3'b111, 8'h00);
        do_instr("movwf_status",  1, 0, 3'b000, 8'hA5, 0, 0, 1, 5'h03, 0, 0, 0, 4'b1000, 3'b000, 8'hA5);
        do_instr("andwf_status",  1, 0, 3'b100, 8'h00, 0, 0, 1, 5'h03, 0, 0, 0, 4'b1100, 3'b100, 8'h00);
        do_instr("squash",        1, 1, 3'b111, 8'h5A, 1, 0, 0, 5'h00, 0, 0, 0, 4'b0000, 3'b100, 8'h00);
        do_instr("stall_q3",      1, 0, 3'b011, 8'h81, 1, 0, 0, 5'h00, 0, 3, 0, 4'b0011, 3'b001, 8'h81);
        do_instr("stall_q2",      1, 0, 3'b001, 8'h10, 0, 1, 0, 5'h00, 2, 0, 0, 4'b0001, 3'b010, 8'h10);
        do_instr("invalid",       0, 0, 3'b111, 8'h00, 1, 1, 1, 5'h03, 0, 0, 0, 4'b0000, 3'b010, 8'h10);
        do_instr("other_file",    1, 0, 3'b000, 8'h77, 1, 1, 1, 5'h13, 0, 0, 0, 4'b0000, 3'b010, 8'h10);
        do_instr("reset_in_q3",   1, 0, 3'b111, 8'hFF, 0, 0, 0, 5'h00, 0, 0, 1, 4'b0111, 3'b000, 8'hFF);
        do_instr("after_reset",   1, 0, 3'b000, 8'h00, 1, 0, 1, 5'h03, 0, 0, 0, 4'b1000, 3'b101, 8'h00);
        ex_valid = 1'b0;
        repeat (4) @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach the end, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
